// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder, multiplier
// FSM encoding and the iteration count of the shift-add multiplier.
package alu_pkg;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluMul = 3'b100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mul_state_e;

  localparam int unsigned MulSteps = 32;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per clock, MulSteps steps,
// then a single DONE cycle presenting the low Width bits of the product.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] product
);

  localparam logic [4:0] LastStep = 5'(MulSteps - 1);

  mul_state_e       state_q;
  logic [4:0]       cnt_q;
  logic [Width-1:0] mcand_q;
  logic [Width-1:0] mplier_q;
  logic [Width-1:0] acc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= op_a_i;
            mplier_q <= op_b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == LastStep) begin
            state_q <= StDone;
          end
        end
        // Pipeline advances on this edge, so the held MUL is never re-launched.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StBusy);
  assign done    = (state_q == StDone);
  assign product = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, multi-cycle MUL that stalls the
// pipeline until the product is ready.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             stall_o
);

  alu_ctrl_e        op;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] logic_result;

  assign op     = alu_ctrl_e'(ALUCtrl_i);
  assign is_mul = valid_i && (op == AluMul);

  // The multiplier only honours start while idle, but gate it here too so stall_o
  // is not double-counted in BUSY/DONE.
  assign mul_start = is_mul && !mul_busy && !mul_done;

  shift_add_multiplier #(
    .Width(WIDTH)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .start  (mul_start),
    .op_a_i (data1_i),
    .op_b_i (data2_i),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Unlisted codes, and MUL without a valid instruction, fall through to ADD.
  always_comb begin
    logic_result = '0;
    case (op)
      AluAnd:  logic_result = data1_i & data2_i;
      AluOr:   logic_result = data1_i | data2_i;
      AluSub:  logic_result = data1_i - data2_i;
      default: logic_result = data1_i + data2_i;
    endcase
  end

  always_comb begin
    data_o = logic_result;
    if (mul_done) begin
      data_o = mul_product;
    end else if (mul_busy || is_mul) begin
      data_o = '0;
    end
  end

  assign zero_o  = (data_o == '0);
  assign stall_o = rst_i && (mul_start || mul_busy);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: cycle-level reference model plus directed
// vectors with literal expectations.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [2:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] data_o;
  logic        zero_o;
  logic        stall_o;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(
    .WIDTH(32)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .valid_i  (valid),
    .ALUCtrl_i(ctrl),
    .data1_i  (a),
    .data2_i  (b),
    .data_o   (data_o),
    .zero_o   (zero_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a MUL occupies EX for one launch cycle, 32 stalled cycles and a
  // result cycle; the product is simply a*b truncated to 32 bits.
  int          m_left;
  bit          m_done;
  logic [31:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (valid && ctrl == 3'b100) begin
      m_prod <= a * b;
      m_left <= 32;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_d;
    logic        exp_s;
    if (m_left > 0) begin
      exp_d = '0;
      exp_s = 1'b1;
    end else if (m_done) begin
      exp_d = m_prod;
      exp_s = 1'b0;
    end else if (valid && ctrl == 3'b100) begin
      exp_d = '0;
      exp_s = rst_n;
    end else begin
      exp_s = 1'b0;
      case (ctrl)
        3'b000:  exp_d = a & b;
        3'b001:  exp_d = a | b;
        3'b110:  exp_d = a - b;
        default: exp_d = a + b;
      endcase
    end
    checks++;
    if (data_o !== exp_d || zero_o !== (exp_d == 0) || stall_o !== exp_s) begin
      failures++;
      $display("FAIL model t=%0t: got data=%h zero=%b stall=%b exp data=%h zero=%b stall=%b",
               $time, data_o, zero_o, stall_o, exp_d, (exp_d == 0), exp_s);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [2:0] c, input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk);
    #1;
    valid = v;
    ctrl  = c;
    a     = x;
    b     = y;
  endtask

  task automatic op_chk(input string name, input logic v, input logic [2:0] c,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_d, input logic exp_z);
    apply(v, c, x, y);
    @(negedge clk);
    #1;
    chk(name, data_o, exp_d);
    chk(name, {31'd0, zero_o}, {31'd0, exp_z});
    chk(name, {31'd0, stall_o}, 32'd0);
  endtask

  // Counts stalled cycles from the current one, then checks the DONE-cycle result.
  task automatic wait_mul(input string name, input logic [31:0] x, input logic [31:0] exp,
                          input bit toggle);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!stall_o) break;
      n++;
      if (toggle && n == 10) begin
        a = ~x;
        b = 32'h1234_5678;
      end
    end
    chk(name, n, 33);
    chk(name, data_o, exp);
    chk(name, {31'd0, stall_o}, 32'd0);
  endtask

  task automatic do_mul(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input bit toggle);
    apply(1'b1, 3'b100, x, y);
    wait_mul(name, x, exp, toggle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    valid = 1'b0;
    ctrl  = 3'b000;
    a     = '0;
    b     = '0;
    @(negedge clk);
    #1;
    chk("reset_data", data_o, 32'd0);
    chk("reset_zero", {31'd0, zero_o}, 32'd1);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    valid = 1'b1;
    ctrl  = 3'b100;
    a     = 32'd5;
    b     = 32'd6;
    #1;
    chk("reset_mul_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_mul_data", data_o, 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    op_chk("add_wrap", 1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
    op_chk("sub_zero", 1'b1, 3'b110, 32'd5, 32'd5, 32'd0, 1'b1);
    op_chk("code011_add", 1'b1, 3'b011, 32'd3, 32'd4, 32'd7, 1'b0);
    op_chk("and", 1'b1, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0);
    op_chk("or", 1'b1, 3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0);
    op_chk("sub_wrap", 1'b1, 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    op_chk("mul_invalid", 1'b0, 3'b100, 32'd3, 32'd4, 32'd7, 1'b0);

    do_mul("mul_6x7", 32'd6, 32'd7, 32'd42, 1'b0);
    op_chk("after_mul_idle", 1'b1, 3'b010, 32'd1, 32'd2, 32'd3, 1'b0);

    do_mul("mul_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    do_mul("mul_neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);
    do_mul("mul_2x3", 32'd2, 32'd3, 32'd6, 1'b0);
    do_mul("mul_4x5", 32'd4, 32'd5, 32'd20, 1'b0);

    // Reset pulsed mid-multiply with 9x9 held on the inputs.
    apply(1'b1, 3'b100, 32'd9, 32'd9);
    n = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      #1;
      if (stall_o) n++;
    end
    chk("rst_mid_pre_stall", n, 11);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mid_data", data_o, 32'd0);
    chk("rst_mid_zero", {31'd0, zero_o}, 32'd1);
    @(negedge clk);
    #1;
    chk("rst_mid_hold_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_mul("mul_9x9_restart", 32'd9, 32'd81, 1'b0);
    op_chk("final_or", 1'b1, 3'b001, 32'h1, 32'h2, 32'h3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU that consumes the 3-bit ALU control code from the ALU control decoder and the two EX operands. It produces the 32-bit result and a zero flag. AND, OR, ADD and SUB complete in the same cycle. MUL runs on an iterative 32-step shift-add datapath and raises a stall to the hazard unit until the product is ready. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- `WIDTH`, default 32, operand and result width.
- `clk_i`  in  1  pipeline clock.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  a real instruction occupies EX; low for bubbles.
- `ALUCtrl_i`  in  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 100 MUL; all other codes execute as ADD.
- `data1_i`  in  WIDTH  operand A (rs, forwarded).
- `data2_i`  in  WIDTH  operand B (rt or immediate, forwarded).
- `data_o`  out  WIDTH  result.
- `zero_o`  out  1  high when `data_o` equals 0.
- `stall_o`  out  1  freezes PC, IF/ID and ID/EX; inserts a bubble into EX/MEM.

## Operation
- States: IDLE, BUSY, DONE (2-bit encoding). There is also an iteration counter `cnt` [4:0], a multiplicand register `mcand` [WIDTH-1:0], a multiplier register `mplier` [WIDTH-1:0] and an accumulator `acc` [WIDTH-1:0].
- IDLE, non-MUL code, or `valid_i` low:
  - `data_o` is the combinational result: A&B, A|B, A+B, or A-B.
  - ADD and SUB wrap modulo 2^WIDTH. There is no overflow detection.
  - `stall_o` is 0.
- IDLE, with `valid_i` high and code 100:
  - `stall_o` is 1 combinationally in that same cycle.
  - `data_o` is 0.
  - At the clock edge: load A into `mcand`, load B into `mplier`, clear `acc`, clear `cnt`, go to BUSY.
- BUSY, on each edge:
  - If `mplier[0]` is 1, `acc` gets `acc` plus `mcand`.
  - `mcand` shifts left by 1 and `mplier` shifts right by 1.
  - `cnt` increments by 1.
  - When `cnt` equals 31, go to DONE.
  - `stall_o` is 1 and `data_o` is 0 throughout.
- DONE:
  - `stall_o` is 0 and `data_o` is `acc`: the low WIDTH bits of the product, identical for signed and unsigned operands.
  - The next edge always returns to IDLE. The pipeline advances on that same edge, so the held MUL is not restarted.
- While `stall_o` is high, upstream holds `valid_i`, `ALUCtrl_i` and the operands stable. Operand changes during BUSY are ignored because the operands were latched on entry.
- `zero_o` is always derived from `data_o` as currently driven.
- `valid_i` dropping during BUSY: ignored; the multiply completes.

## Timing
- Non-MUL operations: 0 added cycles, purely combinational through to `data_o`.
- MUL present in cycle t (IDLE):
  - Cycles t through t+32: `stall_o` is 1, which is 33 cycles.
  - Cycle t+33 (DONE): result valid, `stall_o` is 0, and EX/MEM captures the result at the end of t+33.
  - The instruction occupies EX for 34 cycles in total.
- Back-to-back MULs: the second MUL is seen in IDLE at t+34 and starts immediately.
- Reset asserted (`rst_i` low), including mid-BUSY:
  - State goes to IDLE; `cnt`, `mcand`, `mplier` and `acc` go to 0 asynchronously.
  - `stall_o` is forced to 0 while `rst_i` is low.
  - `data_o` and `zero_o` follow the IDLE combinational rules, with MUL driving 0.
  - After release, a MUL held on the inputs starts fresh.

## Structure
- A shared package `alu_pkg` holds:
  - the ALU control code constants AND, OR, ADD, SUB and MUL, also used by the ALU control decoder;
  - the state encoding constants IDLE, BUSY and DONE;
  - `MUL_STEPS` = 32.
- Sub-module `shift_add_multiplier` holds the `mcand`, `mplier` and `acc` registers plus the counter. Its ports are `start`, `busy`, `done` and `product`. The top level keeps the combinational logic ops, result muxing, the zero flag and `stall_o` generation.

## Test plan
- ADD 0x7FFFFFFF + 1 → `data_o` is 0x80000000, `zero_o` is 0, `stall_o` is 0. SUB 5 − 5 → `data_o` is 0, `zero_o` is 1.
- Code 011 with A=3, B=4 → `data_o` is 7 (defaults to ADD). AND 0xF0F0 with 0x0FF0 → 0x00F0. OR → 0xFFF0.
- MUL 6 × 7 → `stall_o` high for exactly 33 cycles, then `data_o` is 42 for one cycle with `stall_o` 0; the next cycle is IDLE.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000001. MUL −3 × 5 → 0xFFFFFFF1. Operands toggled during BUSY do not change the result.
- Two consecutive MULs, 2×3 then 4×5 → results 6 and 20, each preceded by a 33-cycle stall, with no extra gap.
- Reset pulsed at BUSY step 10 → `stall_o` drops immediately and state is IDLE. After release, the held MUL 9×9 restarts and yields 81 after a full 33-cycle stall.
